// File: rtl/mips_register_file.sv
`default_nettype none
// ============================================================================
// mips_register_file -- 32 x 32 GPR file, two combinational read ports, one
// write port, r0 hard-wired to zero, optional write-to-read bypass.
// Revision: 1.0
// ============================================================================
module mips_register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned C_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [C_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (we && (rd_addr != '0)) begin
      r_regs[rd_addr] <= rd_data;
    end
  end

  // Priority: reset, then r0, then bypass of the in-flight write, then array.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] v;
    v = r_regs[addr];
    if (reset || (addr == '0)) begin
      v = '0;
    end else if (BYPASS && we && (rd_addr == addr)) begin
      v = rd_data;
    end
    return v;
  endfunction

  always_comb begin
    rs_data = read_port(rs_addr);
    rt_data = read_port(rt_addr);
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_register_file.sv
`default_nettype none
// Directed self-checking bench; runs one bypassing and one non-bypassing copy side by side.
module tb_mips_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic        we;
  logic [31:0] rd_data;
  logic [31:0] rs1, rt1, rs0, rt0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) u_dut_byp (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs1), .rt_data(rt1), .we(we), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) u_dut_nobyp (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs0), .rt_data(rt0), .we(we), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks run 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_rs1, input logic [31:0] e_rt1,
                           input logic [31:0] e_rs0, input logic [31:0] e_rt0);
    settle();
    check_eq({tag, "/rs_byp"},   rs1, e_rs1);
    check_eq({tag, "/rt_byp"},   rt1, e_rt1);
    check_eq({tag, "/rs_nobyp"}, rs0, e_rs0);
    check_eq({tag, "/rt_nobyp"}, rt0, e_rt0);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; rd_addr = a; rd_data = d;
    tick();
    we = 1'b0; rd_addr = '0; rd_data = '0;
  endtask

  function automatic logic [31:0] pattern(input int idx);
    logic [31:0] p;
    p = 32'(idx) * 32'h0101_0101;
    return p;
  endfunction

  initial begin
    logic [31:0] alu_f;
    reset = 1'b1; we = 1'b0; rd_addr = '0; rd_data = '0; rs_addr = '0; rt_addr = '0;
    tick();

    // Reset with a pending write to r3: outputs held at 0, write dropped.
    we = 1'b1; rd_addr = 5'd3; rd_data = 32'hFFFF_FFFF; rs_addr = 5'd3; rt_addr = 5'd3;
    check_all("in_reset", 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    reset = 1'b0; we = 1'b0; rd_addr = '0; rd_data = '0;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      check_all("post_reset", 32'h0, 32'h0, 32'h0, 32'h0);
      #1;
    end

    // ALU operand path: r1 + r2 -> r3.
    write_reg(5'd1, 32'h0101_0101);
    write_reg(5'd2, 32'h6161_6161);
    rs_addr = 5'd1; rt_addr = 5'd2;
    check_all("rs_rt", 32'h0101_0101, 32'h6161_6161, 32'h0101_0101, 32'h6161_6161);
    alu_f = 32'h6262_6262;
    write_reg(5'd3, alu_f);
    rs_addr = 5'd3; rt_addr = 5'd3;
    check_all("alu_wb", 32'h6262_6262, 32'h6262_6262, 32'h6262_6262, 32'h6262_6262);

    // Write to r0 is ignored, including on the bypass path.
    we = 1'b1; rd_addr = 5'd0; rd_data = 32'hDEAD_BEEF; rs_addr = 5'd0; rt_addr = 5'd0;
    check_all("r0_wcycle", 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    we = 1'b0; rd_addr = '0; rd_data = '0;
    check_all("r0_next", 32'h0, 32'h0, 32'h0, 32'h0);

    // Simultaneous read/write of r5.
    write_reg(5'd5, 32'h1111_1111);
    we = 1'b1; rd_addr = 5'd5; rd_data = 32'h8101_0101; rs_addr = 5'd5; rt_addr = 5'd5;
    check_all("byp_wcycle", 32'h8101_0101, 32'h8101_0101, 32'h1111_1111, 32'h1111_1111);
    tick();
    we = 1'b0; rd_addr = '0; rd_data = '0;
    check_all("byp_next", 32'h8101_0101, 32'h8101_0101, 32'h8101_0101, 32'h8101_0101);

    // Back-to-back writes to the same index.
    rs_addr = 5'd9; rt_addr = 5'd9;
    write_reg(5'd9, 32'hAAAA_0001);
    check_all("b2b_first", 32'hAAAA_0001, 32'hAAAA_0001, 32'hAAAA_0001, 32'hAAAA_0001);
    we = 1'b1; rd_addr = 5'd9; rd_data = 32'hBBBB_0002;
    tick();
    we = 1'b1; rd_addr = 5'd9; rd_data = 32'hCCCC_0003;
    check_all("b2b_mid", 32'hCCCC_0003, 32'hCCCC_0003, 32'hBBBB_0002, 32'hBBBB_0002);
    tick();
    we = 1'b0; rd_addr = '0; rd_data = '0;
    check_all("b2b_last", 32'hCCCC_0003, 32'hCCCC_0003, 32'hCCCC_0003, 32'hCCCC_0003);

    // Fill r1..r31 and read all (i, 31-i) pairs.
    for (int i = 1; i < 32; i++) write_reg(5'(i), pattern(i));
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      check_all("fill", pattern(i), pattern(31 - i), pattern(i), pattern(31 - i));
      #1;
    end

    // Reset mid-stream with a write to r7 in flight.
    reset = 1'b1; we = 1'b1; rd_addr = 5'd7; rd_data = 32'h7777_7777;
    rs_addr = 5'd7; rt_addr = 5'd31;
    check_all("mid_reset", 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    reset = 1'b0; we = 1'b0; rd_addr = '0; rd_data = '0;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      check_all("after_reset", 32'h0, 32'h0, 32'h0, 32'h0);
      #1;
    end
    rs_addr = 5'd7; rt_addr = 5'd7;
    write_reg(5'd7, 32'h0000_0007);
    check_all("r7_after", 32'h7, 32'h7, 32'h7, 32'h7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_register_file.md
# mips_register_file

General-purpose register file of the MiniMips datapath, sitting directly upstream of `alu_32_bit`. It stores 32 x 32-bit registers, supplies the ALU's A and B operands through two read ports (rs, rt), and accepts one write-back per clock (rd). Register 0 is hard-wired to zero. An optional same-cycle write-to-read bypass lets the ALU see a result in the cycle it is written back.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register width; equals the ALU operand width.
- `ADDR_WIDTH`, 5, register index width; depth = 2**ADDR_WIDTH.
- `BYPASS`, 1, 1 = a read of the register being written returns the write data in the same cycle; 0 = the read returns the old contents.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rs_addr`  in  ADDR_WIDTH  read port A index.
- `rt_addr`  in  ADDR_WIDTH  read port B index.
- `rs_data`  out  DATA_WIDTH  read port A data; drives ALU A.
- `rt_data`  out  DATA_WIDTH  read port B data; drives ALU B.
- `we`  in  1  write enable.
- `rd_addr`  in  ADDR_WIDTH  write index.
- `rd_data`  in  DATA_WIDTH  write data, normally the ALU result F.

## Operation
- Storage: 2**ADDR_WIDTH registers. Entry 0 is never written; it always reads 0.
- Write: on a rising edge with `reset`=0, `we`=1 and `rd_addr`!=0, `rd_data` is stored in `regs[rd_addr]`. When `we`=1 and `rd_addr`=0, nothing is stored and no error is raised.
- Reset: on a rising edge with `reset`=1, every register is cleared to 0 in that single edge. Reset takes priority over a write presented in the same cycle, so that write is lost.
- Read: `rs_data`/`rt_data` are combinational functions of the address, the stored array, and the bypass terms. Either port may use any index, and both ports may use the same index.
- Read priority, highest first:
  1. `reset`=1 forces 0.
  2. An address of 0 returns 0.
  3. With `BYPASS`=1, `we`=1 and `rd_addr`==read address, the port returns `rd_data`.
  4. Otherwise the port returns `regs[addr]`.
- No internal state machine. The block has no stall or handshake: every cycle presents a valid read and at most one write.

## Timing
- Read latency: 0 cycles (combinational from address).
- Write latency: 1 edge. Data is visible on the read port in the cycle after the write edge. With `BYPASS`=1 it is also visible in the write cycle itself.
- Reset: both read outputs are 0 for as long as `reset` is high. After deassertion, every register reads 0 until it is written.
- Reset mid-operation: any write in flight in the reset cycle is dropped. Writes resume on the first edge with `reset`=0.
- Back-to-back writes to the same index: the last write wins; each is visible on the next cycle.
- Simultaneous read and write of the same index:
  - `BYPASS`=1 returns new data.
  - `BYPASS`=0 returns old data; new data appears one cycle later.

## Test plan
- Reset then read all 32 indices on both ports -> every read is 0x00000000. Hold `reset`=1 with `we`=1, `rd_addr`=3, `rd_data`=0xFFFFFFFF for one edge -> r3 still reads 0 after reset is released.
- Write r1=0x01010101 and r2=0x61616161 on consecutive edges, then `rs_addr`=1, `rt_addr`=2 -> `rs_data`=0x01010101, `rt_data`=0x61616161. Driving these into the ALU with S=000 gives F=0x62626262; write F to r3 and read it back -> 0x62626262.
- `we`=1, `rd_addr`=0, `rd_data`=0xDEADBEEF; read r0 in the write cycle and the next cycle -> 0x00000000 both times, including when BYPASS=1.
- Bypass: with `BYPASS`=1 and r5=0x11111111, write 0x81010101 to r5 while `rs_addr`=`rt_addr`=5 -> both ports read 0x81010101 in that cycle. Repeat with `BYPASS`=0 -> 0x11111111 in the write cycle, 0x81010101 in the next.
- Fill r1..r31 with value (index * 0x01010101), then read all pairs (i, 31-i) -> every read matches its index pattern; r0 reads 0.
- Reset mid-stream: after the fill above, assert `reset` for 1 cycle while `we`=1 writes r7 -> all registers read 0 afterwards, including r7. A following write of 0x00000007 to r7 reads back correctly on the next cycle.
